// File: rtl/object_engine_pkg.sv
// Shared types and helpers for the sprite object engine: slot record, FSM
// state codes, player constants and RGB222 colour expansion.
package object_engine_pkg;

   localparam int unsigned POS_W   = 10;
   localparam int unsigned SIZE_W  = 6;
   localparam int unsigned SPEED_W = 4;

   localparam logic [SIZE_W-1:0] PLAYER_SIZE   = 6'd32;
   localparam logic [1:0]        PLAYER_BITMAP = 2'b11;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_UPDATE = 1'b1;

   typedef struct packed {
      logic [POS_W-1:0]   pos_h;
      logic [POS_W-1:0]   pos_v;
      logic               exists;
      logic [1:0]         bitmap;
      logic [SIZE_W-1:0]  width;
      logic [SIZE_W-1:0]  height;
      logic [SPEED_W-1:0] speed;
   } slot_t;

   function automatic logic [5:0] expand_color(input logic [1:0] bitmap);
      return {bitmap, 2'b11, bitmap};
   endfunction

endpackage

// File: rtl/object_engine_hit.sv
// Beam-in-rectangle test for one object slot; sums are widened so that
// pos+size never wraps.
module object_hit
   import object_engine_pkg::*;
(
   input  slot_t       slot,
   input  logic [10:0] cntr_h,
   input  logic [9:0]  cntr_v,
   output logic        active
);

   logic [11:0] h_lo, h_hi, v_lo, v_hi, beam_h, beam_v;
   logic        unused_fields;

   assign unused_fields = ^{slot.bitmap, slot.speed};

   always_comb begin
      beam_h = 12'(cntr_h);
      beam_v = 12'(cntr_v);
      h_lo   = 12'(slot.pos_h);
      h_hi   = 12'(slot.pos_h) + 12'(slot.width);
      v_lo   = 12'(slot.pos_v);
      v_hi   = 12'(slot.pos_v) + 12'(slot.height);
      active = slot.exists && (beam_v >= v_lo) && (beam_v < v_hi) &&
               (beam_h >= h_lo) && (beam_h < h_hi);
   end

endmodule

// File: rtl/object_engine.sv
// Sprite bank: player in slot 0, falling obstacles in 1..N-1. Composites the
// beam pixel, walks slots once per frame and latches player collisions.
module object_engine
   import object_engine_pkg::*;
#(
   parameter int unsigned OBJECT_COUNT     = 16,
   parameter int unsigned POS_WIDTH        = POS_W,
   parameter int unsigned SIZE_WIDTH       = SIZE_W,
   parameter int unsigned SPEED_WIDTH      = SPEED_W,
   parameter int unsigned H_VISIBLE        = 800,
   parameter int unsigned V_VISIBLE        = 600,
   parameter logic [5:0]  BACKGROUND_COLOR = 6'b010000,
   parameter int unsigned PLAYER_INIT_H    = 550,
   parameter int unsigned PLAYER_INIT_V    = 100
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [10:0]                     cntr_h,
   input  logic [9:0]                      cntr_v,
   input  logic                            shift_object_left,
   input  logic                            shift_object_right,
   input  logic                            spawn_valid,
   output logic                            spawn_ready,
   input  logic [POS_WIDTH-1:0]            spawn_pos_h,
   input  logic [SIZE_WIDTH-1:0]           spawn_width,
   input  logic [SIZE_WIDTH-1:0]           spawn_height,
   input  logic [1:0]                      spawn_bitmap,
   input  logic [SPEED_WIDTH-1:0]          spawn_speed,
   output logic [5:0]                      pixel,
   output logic                            collision,
   output logic [$clog2(OBJECT_COUNT)-1:0] active_count
);

   localparam int unsigned IDX_W = $clog2(OBJECT_COUNT);
   localparam logic [POS_WIDTH-1:0] PLAYER_MAX_H = POS_WIDTH'(H_VISIBLE - int'(PLAYER_SIZE));

   localparam slot_t PLAYER_RESET = '{
      pos_h:  POS_WIDTH'(PLAYER_INIT_H),
      pos_v:  POS_WIDTH'(PLAYER_INIT_V),
      exists: 1'b1,
      bitmap: PLAYER_BITMAP,
      width:  PLAYER_SIZE,
      height: PLAYER_SIZE,
      speed:  '0
   };

   slot_t                   slot_q [OBJECT_COUNT];
   logic [0:0]              state_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    sticky_q, collision_q;
   logic [5:0]              pixel_q, pixel_d;
   logic [IDX_W-1:0]        count_q, count_d;
   logic [OBJECT_COUNT-1:0] active;
   logic                    tick, free_found, obstacle_hit;
   logic [IDX_W-1:0]        free_idx;
   logic [POS_WIDTH:0]      new_v;
   slot_t                   spawn_slot;

   for (genvar g = 0; g < OBJECT_COUNT; g++) begin : g_hit
      object_hit u_hit (
         .slot   (slot_q[g]),
         .cntr_h (cntr_h),
         .cntr_v (cntr_v),
         .active (active[g])
      );
   end

   assign tick = (cntr_h == 11'(H_VISIBLE)) && (cntr_v == 10'(V_VISIBLE));

   // Lowest free obstacle slot wins the allocation.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = OBJECT_COUNT - 1; i >= 1; i--) begin
         if (!slot_q[i].exists) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign spawn_ready = (state_q == ST_IDLE) && !tick && !rst && free_found;

   always_comb begin
      spawn_slot = '{
         pos_h:  spawn_pos_h,
         pos_v:  '0,
         exists: 1'b1,
         bitmap: spawn_bitmap,
         width:  spawn_width,
         height: spawn_height,
         speed:  spawn_speed
      };
      new_v = {1'b0, slot_q[idx_q].pos_v} + (POS_WIDTH + 1)'(slot_q[idx_q].speed);
   end

   // Walk downwards so the lowest active index ends up on top.
   always_comb begin
      pixel_d      = BACKGROUND_COLOR;
      obstacle_hit = 1'b0;
      count_d      = '0;
      for (int i = OBJECT_COUNT - 1; i >= 0; i--) begin
         if (active[i]) pixel_d = expand_color(slot_q[i].bitmap);
      end
      for (int i = 1; i < OBJECT_COUNT; i++) begin
         obstacle_hit = obstacle_hit | active[i];
         count_d      = count_d + IDX_W'(slot_q[i].exists);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         sticky_q    <= 1'b0;
         collision_q <= 1'b0;
         pixel_q     <= BACKGROUND_COLOR;
         count_q     <= '0;
         for (int i = 1; i < OBJECT_COUNT; i++) slot_q[i] <= '0;
         slot_q[0] <= PLAYER_RESET;
      end else begin
         pixel_q <= pixel_d;
         count_q <= count_d;
         if (active[0] && obstacle_hit) sticky_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  if (shift_object_right) begin
                     if (slot_q[0].pos_h < PLAYER_MAX_H)
                        slot_q[0].pos_h <= slot_q[0].pos_h + POS_WIDTH'(1);
                  end else if (shift_object_left) begin
                     if (slot_q[0].pos_h != '0)
                        slot_q[0].pos_h <= slot_q[0].pos_h - POS_WIDTH'(1);
                  end
                  collision_q <= sticky_q;
                  sticky_q    <= 1'b0;
                  state_q     <= ST_UPDATE;
                  idx_q       <= IDX_W'(1);
               end else if (spawn_valid && spawn_ready) begin
                  slot_q[free_idx] <= spawn_slot;
               end
            end
            default: begin
               if (slot_q[idx_q].exists) begin
                  if (new_v >= (POS_WIDTH + 1)'(V_VISIBLE)) slot_q[idx_q].exists <= 1'b0;
                  else slot_q[idx_q].pos_v <= new_v[POS_WIDTH-1:0];
               end
               if (idx_q == IDX_W'(OBJECT_COUNT - 1)) state_q <= ST_IDLE;
               else idx_q <= idx_q + IDX_W'(1);
            end
         endcase
      end
   end

   assign pixel        = pixel_q;
   assign collision    = collision_q;
   assign active_count = count_q;

endmodule

// File: doc/object_engine.md
# object_engine

Parametrised successor to the fixed three-object sprite bank in the VGA game pipeline. Holds `OBJECT_COUNT` object slots. Slot 0 is the player; slots 1..N-1 are falling obstacles.

- **Pixel path:** composites them against the background for the current beam position.
- **Per-frame update:** moves every object by its own speed.
- **Retirement:** retires objects that leave the screen.
- **Spawning:** accepts new objects through a valid/ready port.
- **Collision:** reports player collisions once per frame.

It sits between the VGA timing counters and the colour DAC output stage.

## Interface
Parameters:
- `OBJECT_COUNT`, 16, total slots including player (>= 2)
- `POS_WIDTH`, 10, width of `pos_h` and `pos_v`
- `SIZE_WIDTH`, 6, width of object width and height
- `SPEED_WIDTH`, 4, width of per-object vertical speed
- `H_VISIBLE`, 800, visible pixels per line; also the frame-tick column
- `V_VISIBLE`, 600, visible lines; also the frame-tick row
- `BACKGROUND_COLOR`, 6'b010000, colour where no object is active
- `PLAYER_INIT_H` / `PLAYER_INIT_V`, 550 / 100, player reset position; player size is 32x32, bitmap 2'b11

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset; asynchronous, active-high
- `cntr_h`  in  11  beam column
- `cntr_v`  in  10  beam row
- `shift_object_left` / `shift_object_right`  in  1  player steering, sampled at frame tick
- `spawn_valid`  in  1  spawn request
- `spawn_ready`  out  1  spawn accepted this cycle if `spawn_valid` is also high
- `spawn_pos_h`  in  POS_WIDTH  initial column
- `spawn_width` / `spawn_height`  in  SIZE_WIDTH  object size
- `spawn_bitmap`  in  2  colour code
- `spawn_speed`  in  SPEED_WIDTH  rows moved per frame
- `pixel`  out  6  composited RGB222
- `collision`  out  1  player overlapped an obstacle during the previous frame
- `active_count`  out  $clog2(OBJECT_COUNT)  number of live obstacles in slots 1..N-1

## Operation
**Slot contents:** each slot holds `pos_h`, `pos_v`, `exists`, `bitmap`, `width`, `height`, `speed`.

**Reset values:**
- Slot 0: `exists=1`, init position, size 32x32, bitmap 11, speed 0.
- Other slots: `exists=0`.
- Outputs: `pixel=BACKGROUND_COLOR`, `collision=0`, `active_count=0`, `spawn_ready=0` while `rst` is high.

**Frame tick:** `tick = (cntr_h==H_VISIBLE && cntr_v==V_VISIBLE)`, true for one cycle per frame.

**FSM states: IDLE, UPDATE.**
- IDLE, on `tick`:
  - Steer the player. Right has priority over left.
  - Step is 1, clamped to 0..H_VISIBLE-width with no wrap.
  - Copy the sticky collision flag to `collision`, then clear the sticky flag.
  - Go to UPDATE with slot index = 1.
- UPDATE, one slot per cycle:
  - If the slot exists: `new_v = pos_v + speed`, computed in POS_WIDTH+1 bits.
  - If `new_v >= V_VISIBLE`, clear `exists`; otherwise `pos_v <= new_v`.
  - After slot N-1, return to IDLE. UPDATE lasts exactly N-1 cycles.

**Spawn:**
- `spawn_ready = state==IDLE && !tick && !rst && (any slot in 1..N-1 has exists==0)`.
- On `spawn_valid && spawn_ready`, write the lowest-index free slot: `pos_v=0`, `exists=1`, other fields from the port.
- `spawn_ready` is low during UPDATE and on the tick cycle; the requester holds `spawn_valid`. A tick coinciding with a request: the tick wins.
- A speed of 0 is legal; such an object never retires.

**Hit test per slot:**
- `active = exists && cntr_v >= pos_v && cntr_v < pos_v+height && cntr_h >= pos_h && cntr_h < pos_h+width`.
- Sums are computed one bit wider so `pos+size` never wraps.
- `cntr_h` is compared zero-extended.

**Compositing:**
- Lowest active index wins; slot 0 is drawn on top.
- Colour is `{bitmap, 2'b11, bitmap}`; if no slot is active, `BACKGROUND_COLOR`.

**Collision:** the sticky flag sets on any cycle where slot 0 is active and any slot 1..N-1 is active.

**`active_count`:** a registered popcount of `exists[1..N-1]`.

## Timing
- `pixel` is registered: the colour for beam position (h,v) appears one clock after (h,v) is presented.
- `collision` updates on the cycle after `tick` and holds for a full frame.
- Slot updates complete N-1 cycles after the tick. For these to finish before visible output resumes, the blanking interval must exceed N cycles (integration constraint).
- `active_count` lags `exists` changes by one cycle.
- Asserting `rst` mid-UPDATE abandons the walk immediately: all slots return to reset values and the FSM returns to IDLE.

## Structure
- **`object_engine_pkg`:**
  - slot record typedef (fields above);
  - FSM state enum;
  - RGB222 colour-expansion function;
  - player size/bitmap constants.
- **Sub-module `object_hit`:**
  - one instance per slot via generate;
  - inputs: slot record and beam counters;
  - output: `active`.
- **Top level:** slot storage, FSM, spawn allocator (priority encoder on `~exists`), compositor, collision latch.

## Test plan
- **Reset:** assert `rst`, release.
  - `pixel=6'b010000` at a background position.
  - Player drawn as 6'b111111 at (550..581, 100..131) one clock after the beam arrives.
  - `active_count=0`.
- **Spawn and fall:** spawn h=120, size 32x32, bitmap 00, speed 3.
  - Lands in slot 1.
  - After 5 ticks `pos_v=15`.
  - Pixel at (120,15) = 6'b001100.
- **Retirement:** obstacle at `pos_v=598`, speed 3.
  - Cleared at the next tick's UPDATE.
  - `active_count` drops 1 -> 0.
- **Full bank:** fill all 15 obstacle slots.
  - `spawn_ready=0`.
  - Retire slot 4; the next spawn goes to slot 4.
- **Tick vs spawn:** hold `spawn_valid` across a tick.
  - `ready` is low on the tick and for 15 UPDATE cycles.
  - Accepted on the first IDLE cycle.
- **Collision and clamp:**
  - Overlap the player with an obstacle for one pixel: `collision=1` for exactly the next frame.
  - Hold right with the player at h=768: h stays 768.
